// File: rtl/sm_pkg.sv
// Shared constants for the sm byte-lane steering block: select encodings and lane width.
package sm_pkg;

  localparam int LANE_W = 8;
  localparam int NUM_LANES = 8;

  localparam logic [2:0] SEL_PASS       = 3'd0;
  localparam logic [2:0] SEL_INTERLEAVE = 3'd1;
  localparam logic [2:0] SEL_SWAP       = 3'd2;
  localparam logic [2:0] SEL_REVERSE    = 3'd3;
  localparam logic [2:0] SEL_BCAST_A    = 3'd4;
  localparam logic [2:0] SEL_BCAST_B    = 3'd5;
  localparam logic [2:0] SEL_XOR        = 3'd6;
  localparam logic [2:0] SEL_CLEAR      = 3'd7;

  // Byte k of a 32-bit source word, byte 0 being the LSB.
  function automatic logic [LANE_W-1:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: LANE_W];
  endfunction

endpackage

// File: rtl/sm_lane_mux.sv
// Next-value mux for one output lane; combinational, no backpressure.
// SM_XOR_MODE_EN: when defined select=6 XORs A/B bytes, otherwise it clears like select=7.
module sm_lane_mux
  import sm_pkg::*;
(
  input  logic [2:0]        lane,
  input  logic [2:0]        select,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic [LANE_W-1:0] nxt
);

  logic       hi;
  logic [1:0] idx;

  assign hi  = lane[2];
  assign idx = lane[1:0];

  always_comb begin
    nxt = '0;
    case (select)
      SEL_PASS:       nxt = hi ? byte_of(b, idx) : byte_of(a, idx);
      SEL_INTERLEAVE: nxt = lane[0] ? byte_of(b, lane[2:1]) : byte_of(a, lane[2:1]);
      SEL_SWAP:       nxt = hi ? byte_of(a, idx) : byte_of(b, idx);
      // 3-k for a 2-bit index is its bitwise complement
      SEL_REVERSE:    nxt = hi ? byte_of(b, ~idx) : byte_of(a, ~idx);
      SEL_BCAST_A:    nxt = byte_of(a, 2'd0);
      SEL_BCAST_B:    nxt = byte_of(b, 2'd0);
`ifdef SM_XOR_MODE_EN
      SEL_XOR:        nxt = hi ? '0 : (byte_of(a, idx) ^ byte_of(b, idx));
`else
      SEL_XOR:        nxt = '0;
`endif
      SEL_CLEAR:      nxt = '0;
      default:        nxt = '0;
    endcase
  end

endmodule

// File: rtl/sm.sv
// Registered 8-lane byte steering of two 32-bit words; 1-cycle latency; enable=0 holds outputs.
// SM_XOR_MODE_EN enables the XOR mode (select=6); undefined, select=6 clears.
module sm
  import sm_pkg::*;
#(
  parameter logic [LANE_W-1:0] RESET_VAL = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        select,
  input  logic [31:0]       R1,
  input  logic [31:0]       R2,
  output logic [LANE_W-1:0] Out1,
  output logic [LANE_W-1:0] Out2,
  output logic [LANE_W-1:0] Out3,
  output logic [LANE_W-1:0] Out4,
  output logic [LANE_W-1:0] Out5,
  output logic [LANE_W-1:0] Out6,
  output logic [LANE_W-1:0] Out7,
  output logic [LANE_W-1:0] Out8
);

  logic [LANE_W-1:0] lane_nxt [NUM_LANES];
  logic [LANE_W-1:0] lane_q   [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sm_lane_mux u_mux (
      .lane   (3'(i)),
      .select (select),
      .a      (R1),
      .b      (R2),
      .nxt    (lane_nxt[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= RESET_VAL;
    end else if (enable) begin
      for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= lane_nxt[i];
    end
  end

  assign Out1 = lane_q[0];
  assign Out2 = lane_q[1];
  assign Out3 = lane_q[2];
  assign Out4 = lane_q[3];
  assign Out5 = lane_q[4];
  assign Out6 = lane_q[5];
  assign Out7 = lane_q[6];
  assign Out8 = lane_q[7];

endmodule

// File: tb/tb_sm.sv
// Bench for sm: directed vector table, hand sequences, and random stimulus against a byte-level model.
module tb_sm;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  select;
  logic [31:0] R1, R2;
  logic [7:0]  Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] RV = 8'h00;
`ifdef SM_XOR_MODE_EN
  localparam logic [63:0] XOR_EXP = 64'h00000000_0000001F;
  localparam bit XOR_ON = 1'b1;
`else
  localparam logic [63:0] XOR_EXP = 64'h0;
  localparam bit XOR_ON = 1'b0;
`endif

  sm #(.RESET_VAL(RV)) dut (
    .clock(clock), .reset(reset), .enable(enable), .select(select),
    .R1(R1), .R2(R2),
    .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
    .Out5(Out5), .Out6(Out6), .Out7(Out7), .Out8(Out8)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Out1 in bits 7:0 up to Out8 in bits 63:56.
  function automatic logic [63:0] outs();
    return {Out8, Out7, Out6, Out5, Out4, Out3, Out2, Out1};
  endfunction

  // Spec-level model: builds the eight output bytes from the mode table.
  function automatic logic [63:0] model(input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2);
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic [7:0]  o [8];
    logic [63:0] r;
    for (int k = 0; k < 4; k++) begin
      a[k] = r1[8*k +: 8];
      b[k] = r2[8*k +: 8];
    end
    for (int k = 0; k < 8; k++) o[k] = 8'h00;
    case (sel)
      3'd0: for (int k = 0; k < 4; k++) begin o[k] = a[k];     o[k+4] = b[k];     end
      3'd1: for (int k = 0; k < 4; k++) begin o[2*k] = a[k];   o[2*k+1] = b[k];   end
      3'd2: for (int k = 0; k < 4; k++) begin o[k] = b[k];     o[k+4] = a[k];     end
      3'd3: for (int k = 0; k < 4; k++) begin o[k] = a[3-k];   o[k+4] = b[3-k];   end
      3'd4: for (int k = 0; k < 8; k++) o[k] = a[0];
      3'd5: for (int k = 0; k < 8; k++) o[k] = b[0];
      3'd6: if (XOR_ON) for (int k = 0; k < 4; k++) o[k] = a[k] ^ b[k];
      default: ;
    endcase
    for (int k = 0; k < 8; k++) r[8*k +: 8] = o[k];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic add(input string n, input logic rs, input logic en, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    vec_t v;
    v.name = n; v.rst = rs; v.en = en; v.sel = s; v.r1 = a; v.r2 = b; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rs, input logic en, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] b);
    reset = rs; enable = en; select = s; R1 = a; R2 = b;
    @(posedge clock);
    #1;
  endtask

  logic [63:0] exp_q;
  logic [63:0] held;

  initial begin
    reset = 1'b1; enable = 1'b0; select = 3'd0; R1 = '0; R2 = '0;

    add("reset0",      1, 1, 3'd0, 32'd16, 32'd15, {8{RV}});
    add("reset1",      1, 1, 3'd0, 32'd16, 32'd15, {8{RV}});
    add("pass",        0, 1, 3'd0, 32'd16, 32'd15, 64'h0000000F_00000010);
    add("interleave",  0, 1, 3'd1, 32'd16, 32'd15, 64'h00000000_00000F10);
    add("swap",        0, 1, 3'd2, 32'd16, 32'd15, 64'h00000010_0000000F);
    add("reverse",     0, 1, 3'd3, 32'h11223344, 32'hAABBCCDD, 64'hDDCCBBAA_44332211);
    add("hold_clear",  0, 0, 3'd7, 32'h11223344, 32'hAABBCCDD, 64'hDDCCBBAA_44332211);
    add("hold_bcast",  0, 0, 3'd5, 32'h01020304, 32'h05060708, 64'hDDCCBBAA_44332211);
    add("xor",         0, 1, 3'd6, 32'd16, 32'd15, XOR_EXP);
    add("bcast_a",     0, 1, 3'd4, 32'h11223344, 32'hAABBCCDD, 64'h44444444_44444444);
    add("bcast_b",     0, 1, 3'd5, 32'h11223344, 32'hAABBCCDD, 64'hDDDDDDDD_DDDDDDDD);
    add("xor_hi",      0, 1, 3'd6, 32'hFF00FF00, 32'h0F0F0F0F,
        XOR_ON ? 64'h00000000_F00FF00F : 64'h0);
    add("clear",       0, 1, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0);
    add("reload",      0, 1, 3'd4, 32'h000000A5, 32'h0, 64'hA5A5A5A5_A5A5A5A5);
    add("reset_mid",   1, 1, 3'd0, 32'hDEADBEEF, 32'hCAFEF00D, {8{RV}});
    add("resume",      0, 1, 3'd0, 32'hDEADBEEF, 32'hCAFEF00D, 64'hCAFEF00D_DEADBEEF);

    @(negedge clock);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].r1, tbl[i].r2);
      check(tbl[i].name, outs(), tbl[i].exp);
    end

    // Select changes while disabled only take effect on the next enabled edge.
    drive(0, 1, 3'd0, 32'h11223344, 32'hAABBCCDD);
    held = 64'hAABBCCDD_11223344;
    check("seq_pass", outs(), held);
    drive(0, 0, 3'd2, 32'h55667788, 32'h99AABBCC);
    check("seq_hold1", outs(), held);
    drive(0, 0, 3'd3, 32'h55667788, 32'h99AABBCC);
    check("seq_hold2", outs(), held);
    drive(0, 1, 3'd2, 32'h55667788, 32'h99AABBCC);
    check("seq_swap", outs(), 64'h55667788_99AABBCC);

    // Reset with enable low still clears.
    drive(1, 0, 3'd1, 32'h1, 32'h2);
    check("seq_reset_en0", outs(), {8{RV}});
    exp_q = {8{RV}};

    for (int n = 0; n < 400; n++) begin
      logic        rs, en;
      logic [2:0]  s;
      logic [31:0] a, b;
      rs = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 3) != 0);
      s  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      drive(rs, en, s, a, b);
      if (rs)      exp_q = {8{RV}};
      else if (en) exp_q = model(s, a, b);
      check($sformatf("rand%0d_sel%0d", n, s), outs(), exp_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
